// File: rtl/dense_seq_mac_pkg.sv
// Shared types and arithmetic helpers for the sequential dense layer.
package dense_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        FIN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in + 1) + 1;
    endfunction

    // Round half-up, drop fraction bits, clamp to a width-bit signed range.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input int                 width,
        input int                 nfrac
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (nfrac > 0)
            r = (acc + (64'sd1 <<< (nfrac - 1))) >>> nfrac;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/dense_seq_mac_if.sv
// Valid/ready stream bundle carrying one packed vector per transfer.
interface dense_seq_mac_if #(
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dense_seq_mac_lane.sv
// One MAC lane: accumulates x*w terms, then adds bias and rounds/saturates.
// DENSE_SEQ_RELU_EN: clamp negative results to zero after saturation.
module dense_mac_lane
    import dense_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NFRAC = 4,
    parameter int N_IN  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en_mac,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    input  logic                    en_fin,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);
    localparam int AW = acc_width(WIDTH, N_IN);

    logic signed [AW-1:0]      r_acc;
    logic signed [WIDTH-1:0]   r_y;
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [AW-1:0]      w_pre;
    logic signed [WIDTH-1:0]   w_sat;
    logic signed [WIDTH-1:0]   w_res;

    assign w_prod = x * w;
    assign w_pre  = r_acc + (AW'(b) <<< NFRAC);
    assign w_sat  = WIDTH'(sat_round(64'(w_pre), WIDTH, NFRAC));

`ifdef DENSE_SEQ_RELU_EN
    assign w_res = w_sat[WIDTH-1] ? '0 : w_sat;
`else
    assign w_res = w_sat;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_y   <= '0;
        end else begin
            if (clr)
                r_acc <= '0;
            else if (en_mac)
                r_acc <= r_acc + AW'(w_prod);
            if (en_fin)
                r_y <= w_res;
        end
    end

    assign y = r_y;

endmodule

// File: rtl/dense_seq_mac.sv
// Time-multiplexed dense layer: N_OUT lanes step serially over N_IN inputs.
// Optional DENSE_SEQ_RELU_EN enables ReLU in every lane.
module dense_seq_mac
    import dense_seq_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NFRAC = 4,
    parameter int N_IN  = 32,
    parameter int N_OUT = 5,
    parameter logic signed [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] W = '0,
    parameter logic signed [N_OUT-1:0][WIDTH-1:0]           B = '0
) (
    input  logic             clk,
    input  logic             reset,
    dense_seq_mac_if.slave   s_in,
    dense_seq_mac_if.master  m_out
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ACC  = ACC;
    localparam logic [1:0] S_FIN  = FIN;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]            r_state;
    logic [N_IN*WIDTH-1:0] r_x;
    logic [IW-1:0]         r_idx;
    logic                  w_clr;
    logic                  w_last;

    assign w_clr  = (r_state == S_IDLE) && s_in.valid;
    assign w_last = (r_idx == IW'(N_IN - 1));

    assign s_in.ready  = (r_state == S_IDLE);
    assign m_out.valid = (r_state == S_HOLD);

    // r_x shifts down each ACC cycle so the current term is always in the low word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (s_in.valid) begin
                        r_x     <= s_in.data;
                        r_idx   <= '0;
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_x   <= r_x >> WIDTH;
                    r_idx <= r_idx + IW'(1);
                    if (w_last)
                        r_state <= S_FIN;
                end
                S_FIN:
                    r_state <= S_HOLD;
                S_HOLD: begin
                    if (m_out.ready)
                        r_state <= S_IDLE;
                end
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_lane
        logic signed [WIDTH-1:0] w_y;

        dense_mac_lane #(
            .WIDTH (WIDTH),
            .NFRAC (NFRAC),
            .N_IN  (N_IN)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clr    (w_clr),
            .en_mac (r_state == S_ACC),
            .x      (r_x[WIDTH-1:0]),
            .w      (W[r_idx][o]),
            .en_fin (r_state == S_FIN),
            .b      (B[o]),
            .y      (w_y)
        );

        assign m_out.data[o*WIDTH +: WIDTH] = w_y;
    end

endmodule

// File: tb/tb_dense_seq_mac.sv
// Directed bench for dense_seq_mac: small 2x3 layer plus 32x5 layer vs model.
module tb_dense_seq_mac;

    localparam int WD     = 9;
    localparam int NF     = 4;
    localparam int SN_IN  = 2;
    localparam int SN_OUT = 3;
    localparam int BN_IN  = 32;
    localparam int BN_OUT = 5;

    // Lane0 W={16,8} B=4, lane1 W={16,16} B=0, lane2 W={8,0} B=0.
    localparam logic [SN_IN*SN_OUT*WD-1:0] SW =
        {9'd0, 9'd16, 9'd8, 9'd8, 9'd16, 9'd16};
    localparam logic [SN_OUT*WD-1:0] SB = {9'd0, 9'd0, 9'd4};

    function automatic logic [BN_IN*BN_OUT*WD-1:0] gen_w();
        logic [BN_IN*BN_OUT*WD-1:0] r;
        r = '0;
        for (int i = 0; i < BN_IN; i++)
            for (int o = 0; o < BN_OUT; o++)
                r[(i*BN_OUT+o)*WD +: WD] = 9'((i*7 + o*13 + 3) % 41 - 20);
        return r;
    endfunction

    function automatic logic [BN_OUT*WD-1:0] gen_b();
        logic [BN_OUT*WD-1:0] r;
        r = '0;
        for (int o = 0; o < BN_OUT; o++)
            r[o*WD +: WD] = 9'((o*37) % 61 - 30);
        return r;
    endfunction

    localparam logic [BN_IN*BN_OUT*WD-1:0] BW = gen_w();
    localparam logic [BN_OUT*WD-1:0]       BB = gen_b();

    logic clk = 1'b0;
    logic rst_s = 1'b0;
    logic rst_b = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dense_seq_mac_if #(.DW(SN_IN*WD))  si();
    dense_seq_mac_if #(.DW(SN_OUT*WD)) so();
    dense_seq_mac_if #(.DW(BN_IN*WD))  bi();
    dense_seq_mac_if #(.DW(BN_OUT*WD)) bo();

    dense_seq_mac #(
        .WIDTH(WD), .NFRAC(NF), .N_IN(SN_IN), .N_OUT(SN_OUT),
        .W(SW), .B(SB)
    ) u_small (
        .clk(clk), .reset(rst_s), .s_in(si), .m_out(so)
    );

    dense_seq_mac #(
        .WIDTH(WD), .NFRAC(NF), .N_IN(BN_IN), .N_OUT(BN_OUT),
        .W(BW), .B(BB)
    ) u_big (
        .clk(clk), .reset(rst_b), .s_in(bi), .m_out(bo)
    );

    function automatic int act(input int v);
`ifdef DENSE_SEQ_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [SN_OUT*WD-1:0] exp_s(input int a, b, c);
        logic [WD-1:0] ea, eb, ec;
        ea = WD'(act(a));
        eb = WD'(act(b));
        ec = WD'(act(c));
        return {ec, eb, ea};
    endfunction

    function automatic logic [BN_OUT*WD-1:0] model(
        input logic [BN_IN*WD-1:0] x
    );
        logic [BN_OUT*WD-1:0] r;
        r = '0;
        for (int o = 0; o < BN_OUT; o++) begin
            int acc = 0;
            for (int i = 0; i < BN_IN; i++)
                acc += int'($signed(x[i*WD +: WD])) *
                       int'($signed(BW[(i*BN_OUT+o)*WD +: WD]));
            acc += int'($signed(BB[o*WD +: WD])) * 16;
            acc = (acc + 8) >>> 4;
            if (acc > 255) acc = 255;
            if (acc < -256) acc = -256;
            r[o*WD +: WD] = WD'(act(acc));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_s(input int x0, input int x1,
                         input logic [SN_OUT*WD-1:0] e, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(si.ready), 64'd1);
        si.valid = 1'b1;
        si.data  = {9'(x1), 9'(x0)};
        @(posedge clk);
        #1 si.valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!so.valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(SN_IN + 2));
        chk({tag, "_data"}, 64'(so.data), 64'(e));
        so.ready = 1'b1;
        @(posedge clk);
        #1 so.ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {62'd0, so.valid, si.ready}, 64'd1);
    endtask

    task automatic run_b(input logic [BN_IN*WD-1:0] x, input string tag);
        int lat;
        logic [BN_OUT*WD-1:0] e;
        e = model(x);
        @(negedge clk);
        bi.valid = 1'b1;
        bi.data  = x;
        @(posedge clk);
        #1 bi.valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bo.valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(BN_IN + 2));
        chk({tag, "_data"}, 64'(bo.data), 64'(e));
        bo.ready = 1'b1;
        @(posedge clk);
        #1 bo.ready = 1'b0;
    endtask

    function automatic logic [BN_IN*WD-1:0] rand_x();
        logic [BN_IN*WD-1:0] r;
        for (int i = 0; i < BN_IN; i++)
            r[i*WD +: WD] = 9'($urandom_range(0, 511));
        return r;
    endfunction

    initial begin
        logic [SN_OUT*WD-1:0] e1, e2;
        logic [BN_IN*WD-1:0]  bx;
        int lat;

        si.valid = 1'b0; si.data = '0; so.ready = 1'b0;
        bi.valid = 1'b0; bi.data = '0; bo.ready = 1'b0;

        @(negedge clk);
        rst_s = 1'b1; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_s = 1'b0; rst_b = 1'b0;
        chk("rst_s_valid", 64'(so.valid), 64'd0);
        chk("rst_s_data",  64'(so.data),  64'd0);
        chk("rst_s_ready", 64'(si.ready), 64'd1);
        chk("rst_b_valid", 64'(bo.valid), 64'd0);
        chk("rst_b_ready", 64'(bi.ready), 64'd1);

        run_s(32, 16, exp_s(44, 48, 16), "v1");
        run_s(255, 255, exp_s(255, 255, 128), "sat_pos");
        run_s(-256, -256, exp_s(-256, -256, -128), "sat_neg");
        run_s(1, 0, exp_s(5, 1, 1), "rnd_pos");
        run_s(-1, 0, exp_s(3, -1, 0), "rnd_half");

        // Backpressure: a second vector waits at the input during HOLD.
        e1 = exp_s(44, 48, 16);
        e2 = exp_s(255, 255, 128);
        @(negedge clk);
        si.valid = 1'b1;
        si.data  = {9'd16, 9'd32};
        @(posedge clk);
        #1 si.data = {9'd255, 9'd255};
        lat = 1;
        @(negedge clk);
        while (!so.valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_lat", 64'(lat), 64'(SN_IN + 2));
        for (int k = 0; k < 10; k++) begin
            chk("bp_data", 64'(so.data), 64'(e1));
            chk("bp_busy", {62'd0, so.valid, si.ready}, 64'd2);
            @(negedge clk);
        end
        so.ready = 1'b1;
        @(posedge clk);
        #1 so.ready = 1'b0;
        @(negedge clk);
        chk("bp_idle", {62'd0, so.valid, si.ready}, 64'd1);
        @(posedge clk);
        #1 si.valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!so.valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("bp2_lat", 64'(lat), 64'(SN_IN + 2));
        chk("bp2_data", 64'(so.data), 64'(e2));
        so.ready = 1'b1;
        @(posedge clk);
        #1 so.ready = 1'b0;

        // Reset in the middle of accumulation on the large layer.
        @(negedge clk);
        bi.valid = 1'b1;
        bi.data  = rand_x();
        @(posedge clk);
        #1 bi.valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        chk("mid_rst_valid", 64'(bo.valid), 64'd0);
        chk("mid_rst_ready", 64'(bi.ready), 64'd1);
        chk("mid_rst_data",  64'(bo.data),  64'd0);

        run_b('0, "b_zero");
        for (int t = 0; t < 6; t++) begin
            bx = rand_x();
            run_b(bx, $sformatf("b_rand%0d", t));
        end
        for (int i = 0; i < BN_IN; i++)
            bx[i*WD +: WD] = 9'($signed(i % 5) - 2);
        run_b(bx, "b_small");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
